// File: rtl/alu_ctl_pipe.sv
// ============================================================================
// Module   : alu_ctl_pipe
// Brief    : Registered ALU-control decoder for ID/EX with mult/div issue FSM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ctl_pipe #(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int CTR_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               stall,
  input  logic               flush,
  output logic [CTR_W-1:0]   alu_ctr,
  output logic               ctr_valid,
  output logic               illegal,
  output logic               md_busy,
  output logic               md_done
);

  localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_LAT - 1);
  localparam logic [3:0]   c_CODE_ADD = 4'b0010;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   w_nextCount;
  logic [CTR_W-1:0]     r_aluCtr;
  logic                 r_ctrValid;
  logic                 r_illegal;
  logic [3:0]           w_code4;
  logic                 w_illegal;
  logic                 w_isMult;
  logic                 w_isDiv;
  logic                 w_accept;

  // Opcode/funct bits above the decoded range make the operation illegal.
  always_comb begin
    w_code4   = c_CODE_ADD;
    w_illegal = 1'b0;
    w_isMult  = 1'b0;
    w_isDiv   = 1'b0;
    if ((alu_op >> 3) != '0) begin
      w_illegal = 1'b1;
    end else begin
      case (alu_op[2:0])
        3'b000: w_code4 = 4'b0010;
        3'b001: w_code4 = 4'b0110;
        3'b011: w_code4 = 4'b0000;
        3'b100: w_code4 = 4'b0001;
        3'b101: w_code4 = 4'b0111;
        3'b110: w_code4 = 4'b0011;
        3'b111: w_code4 = 4'b1111;
        default: begin
          if ((funct >> 6) != '0) begin
            w_illegal = 1'b1;
          end else begin
            case (funct[5:0])
              6'b100000: w_code4 = 4'b0010;
              6'b100010: w_code4 = 4'b0110;
              6'b100100: w_code4 = 4'b0000;
              6'b100101: w_code4 = 4'b0001;
              6'b100110: w_code4 = 4'b0011;
              6'b100111: w_code4 = 4'b1100;
              6'b101010: w_code4 = 4'b0111;
              6'b101011: w_code4 = 4'b1000;
              6'b000000: w_code4 = 4'b0100;
              6'b000010: w_code4 = 4'b0101;
              6'b000011: w_code4 = 4'b1001;
              6'b011000: begin
                w_code4  = 4'b1010;
                w_isMult = 1'b1;
              end
              6'b011010: begin
                w_code4 = 4'b1011;
                w_isDiv = 1'b1;
              end
              default: w_illegal = 1'b1;
            endcase
          end
        end
      endcase
    end
  end

  assign in_ready  = rst_n & (r_state == S_IDLE) & ~stall & ~flush;
  assign w_accept  = in_valid & in_ready;
  assign md_busy   = (r_state == S_BUSY);
  // An aborting flush suppresses the completion pulse.
  assign md_done   = rst_n & ~flush & (r_state == S_BUSY) & (r_count == '0);
  assign alu_ctr   = r_aluCtr;
  assign ctr_valid = r_ctrValid;
  assign illegal   = r_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    if (flush) begin
      w_nextState = S_IDLE;
      w_nextCount = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (w_isMult || w_isDiv)) begin
            w_nextState = S_BUSY;
            w_nextCount = w_isMult ? c_MUL_LOAD : c_DIV_LOAD;
          end
        end
        default: begin
          if (r_count == '0) begin
            w_nextState = S_IDLE;
          end else begin
            w_nextCount = r_count - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_aluCtr   <= CTR_W'(c_CODE_ADD);
      r_ctrValid <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_ctrValid <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (stall) begin
      r_ctrValid <= r_ctrValid;
    end else if (w_accept) begin
      r_aluCtr   <= CTR_W'(w_code4);
      r_ctrValid <= 1'b1;
      r_illegal  <= w_illegal;
    end else begin
      r_ctrValid <= 1'b0;
      r_illegal  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_ctl_pipe.sv
// ============================================================================
// Module   : tb_alu_ctl_pipe
// Brief    : Directed self-checking bench for alu_ctl_pipe with a reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_ctl_pipe;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       stall;
  logic       flush;
  logic [3:0] alu_ctr;
  logic       ctr_valid;
  logic       illegal;
  logic       md_busy;
  logic       md_done;

  int passCnt = 0;
  int totalCnt = 0;

  alu_ctl_pipe #(
    .ALUOP_W(3), .FUNCT_W(6), .CTR_W(4), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .stall(stall), .flush(flush),
    .alu_ctr(alu_ctr), .ctr_valid(ctr_valid), .illegal(illegal),
    .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference decode straight from the opcode table: {illegal, code}.
  function automatic logic [4:0] refDecode(input logic [2:0] op, input logic [5:0] f);
    case (op)
      3'd0: return {1'b0, 4'h2};
      3'd1: return {1'b0, 4'h6};
      3'd3: return {1'b0, 4'h0};
      3'd4: return {1'b0, 4'h1};
      3'd5: return {1'b0, 4'h7};
      3'd6: return {1'b0, 4'h3};
      3'd7: return {1'b0, 4'hF};
      default: begin
        case (f)
          6'd32: return {1'b0, 4'h2};
          6'd34: return {1'b0, 4'h6};
          6'd36: return {1'b0, 4'h0};
          6'd37: return {1'b0, 4'h1};
          6'd38: return {1'b0, 4'h3};
          6'd39: return {1'b0, 4'hC};
          6'd42: return {1'b0, 4'h7};
          6'd43: return {1'b0, 4'h8};
          6'd0:  return {1'b0, 4'h4};
          6'd2:  return {1'b0, 4'h5};
          6'd3:  return {1'b0, 4'h9};
          6'd24: return {1'b0, 4'hA};
          6'd26: return {1'b0, 4'hB};
          default: return {1'b1, 4'h2};
        endcase
      end
    endcase
  endfunction

  // Model state: busyLeft counts remaining busy cycles including the current one.
  bit         modelReady = 1'b0;
  logic [3:0] mCtr;
  bit         mValid, mIll;
  int         busyLeft = 0;

  function automatic bit mReady();
    return rst_n && busyLeft == 0 && !stall && !flush;
  endfunction

  always @(posedge clk) begin
    logic [4:0] d;
    bit acc;
    acc = in_valid && mReady();
    d = refDecode(alu_op, funct);
    if (!rst_n) begin
      mCtr = 4'h2; mValid = 0; mIll = 0; busyLeft = 0; modelReady = 1'b1;
    end else if (flush) begin
      mValid = 0; mIll = 0; busyLeft = 0;
    end else begin
      if (busyLeft > 0) busyLeft--;
      if (stall) begin
      end else if (acc) begin
        mCtr = d[3:0]; mIll = d[4]; mValid = 1;
        if (alu_op == 3'd2 && funct == 6'd24) busyLeft = MUL_LAT;
        if (alu_op == 3'd2 && funct == 6'd26) busyLeft = DIV_LAT;
      end else begin
        mValid = 0; mIll = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (modelReady) begin
      chk("m_alu_ctr", 32'(alu_ctr), 32'(mCtr));
      chk("m_ctr_valid", 32'(ctr_valid), 32'(mValid));
      chk("m_illegal", 32'(illegal), 32'(mIll));
      chk("m_md_busy", 32'(md_busy), 32'(busyLeft > 0));
      chk("m_md_done", 32'(md_done), 32'(rst_n && !flush && busyLeft == 1));
      chk("m_in_ready", 32'(in_ready), 32'(mReady()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    in_valid = 1'b0;
    #0;
    while (!in_ready && n < 64) begin
      cyc();
      n++;
    end
    if (!in_ready) chk("wait_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] f,
                       input logic [3:0] expCode, input logic expIll);
    waitReady();
    alu_op = op; funct = f; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("lit_alu_ctr", 32'(alu_ctr), 32'(expCode));
    chk("lit_illegal", 32'(illegal), 32'(expIll));
    chk("lit_ctr_valid", 32'(ctr_valid), 32'd1);
  endtask

  typedef struct {logic [2:0] op; logic [5:0] f; logic [3:0] code; logic ill;} vec_t;
  vec_t vecs[$] = '{
    '{3'd0, 6'd0, 4'h2, 1'b0}, '{3'd1, 6'd0, 4'h6, 1'b0}, '{3'd3, 6'd0, 4'h0, 1'b0},
    '{3'd4, 6'd0, 4'h1, 1'b0}, '{3'd5, 6'd0, 4'h7, 1'b0}, '{3'd6, 6'd0, 4'h3, 1'b0},
    '{3'd7, 6'd0, 4'hF, 1'b0},
    '{3'd2, 6'b100000, 4'h2, 1'b0}, '{3'd2, 6'b100010, 4'h6, 1'b0},
    '{3'd2, 6'b100100, 4'h0, 1'b0}, '{3'd2, 6'b100101, 4'h1, 1'b0},
    '{3'd2, 6'b100110, 4'h3, 1'b0}, '{3'd2, 6'b100111, 4'hC, 1'b0},
    '{3'd2, 6'b101010, 4'h7, 1'b0}, '{3'd2, 6'b101011, 4'h8, 1'b0},
    '{3'd2, 6'b000000, 4'h4, 1'b0}, '{3'd2, 6'b000010, 4'h5, 1'b0},
    '{3'd2, 6'b000011, 4'h9, 1'b0}, '{3'd2, 6'b011000, 4'hA, 1'b0},
    '{3'd2, 6'b011010, 4'hB, 1'b0}, '{3'd2, 6'b101111, 4'h2, 1'b1}
  };

  initial begin
    int n, doneAt;
    bit doneSeen;
    rst_n = 0; in_valid = 1; alu_op = 3'd1; funct = 6'd0; stall = 0; flush = 0;

    // Reset held with a pending request.
    repeat (3) cyc();
    chk("rst_alu_ctr", 32'(alu_ctr), 32'h2);
    chk("rst_ctr_valid", 32'(ctr_valid), 32'd0);
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_md_done", 32'(md_done), 32'd0);
    rst_n = 1; in_valid = 0;
    cyc();

    // Decode sweep, mult/div drain inside waitReady.
    foreach (vecs[i]) issue(vecs[i].op, vecs[i].f, vecs[i].code, vecs[i].ill);

    // Mult latency and back-to-back add.
    issue(3'd2, 6'b011000, 4'hA, 1'b0);
    alu_op = 3'd0; funct = 6'd0; in_valid = 1'b1;
    n = 0; doneAt = 0;
    while (md_busy && n < 100) begin
      n++;
      if (md_done) doneAt = n;
      cyc();
    end
    chk("mul_busy_cycles", 32'(n), 32'd4);
    chk("mul_done_cycle", 32'(doneAt), 32'd4);
    chk("mul_next_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("b2b_alu_ctr", 32'(alu_ctr), 32'h2);
    chk("b2b_ctr_valid", 32'(ctr_valid), 32'd1);

    // Stall holds a registered add.
    issue(3'd0, 6'd0, 4'h2, 1'b0);
    stall = 1; in_valid = 1; alu_op = 3'd1;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    repeat (2) begin
      cyc();
      chk("stall_alu_ctr", 32'(alu_ctr), 32'h2);
      chk("stall_ctr_valid", 32'(ctr_valid), 32'd1);
    end
    stall = 0; in_valid = 0;
    cyc();
    chk("stall_bubble", 32'(ctr_valid), 32'd0);

    // Flush during div at busy cycle 10.
    issue(3'd2, 6'b011010, 4'hB, 1'b0);
    repeat (9) cyc();
    chk("div_busy_c10", 32'(md_busy), 32'd1);
    flush = 1;
    cyc();
    flush = 0;
    chk("div_flush_busy", 32'(md_busy), 32'd0);
    chk("div_flush_valid", 32'(ctr_valid), 32'd0);
    doneSeen = 0;
    repeat (40) begin
      if (md_done) doneSeen = 1;
      cyc();
    end
    chk("div_no_done", 32'(doneSeen), 32'd0);

    // Flush + stall + request together.
    issue(3'd0, 6'd0, 4'h2, 1'b0);
    flush = 1; stall = 1; in_valid = 1; alu_op = 3'd1;
    #1;
    chk("fsv_in_ready", 32'(in_ready), 32'd0);
    cyc();
    flush = 0; stall = 0; in_valid = 0;
    chk("fsv_ctr_valid", 32'(ctr_valid), 32'd0);
    chk("fsv_alu_ctr", 32'(alu_ctr), 32'h2);

    // Reset mid-BUSY.
    issue(3'd2, 6'b011000, 4'hA, 1'b0);
    cyc();
    rst_n = 0; in_valid = 1;
    #1;
    chk("rstb_md_done", 32'(md_done), 32'd0);
    chk("rstb_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("rstb_alu_ctr", 32'(alu_ctr), 32'h2);
    chk("rstb_ctr_valid", 32'(ctr_valid), 32'd0);
    chk("rstb_illegal", 32'(illegal), 32'd0);
    chk("rstb_md_busy", 32'(md_busy), 32'd0);
    rst_n = 1; in_valid = 0;
    repeat (2) cyc();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

`default_nettype wire
